// File: rtl/demux1_to_4.sv
// demux1_to_4: routes one source word stream to four independent output
// channels. Each channel has a single holding register with a full flag.
// A channel accepts a new word when it is empty or when its sink drains it
// in the same cycle, so a streaming channel sustains one word per cycle.
//
// Build option: define DEMUX_ROTATE_EN to ignore s and pick the destination
// with an internal round-robin pointer (0,1,2,3,0,...) that advances on each
// accept. Without the macro the destination is taken directly from s.
module demux1_to_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         s,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
);

  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [3:0]            full_q, full_d;
  logic [1:0]            dest;
  logic                  accept;

`ifdef DEMUX_ROTATE_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_s;

  // s has no role when the pointer chooses the destination.
  assign unused_s = ^s;
  assign dest     = ptr_q;

  // Round-robin pointer: advance after every accept, wrap 3 -> 0 naturally.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  // Pointer register, cleared asynchronously with the channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign dest = s;
`endif

  // Ready looks only at the destination channel and its sink, never at in_valid.
  assign in_ready  = !full_q[dest] || out_ready[dest];
  assign accept    = in_valid && in_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  // Next state: drains clear full flags, an accept loads only the destination.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int k = 0; k < 4; k++) begin
      if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
    if (accept) begin
      full_d[dest] = 1'b1;
      data_d[dest] = in_data;
    end
  end

  // Channel holding registers; reset discards every held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 4'b0000;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: doc/demux1_to_4.md
DEMUX1_TO_4 -- requirements
Module: demux1_to_4

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, SHALL be at least 1.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  WIDTH  source word.
REQ-005 in_valid  input  1  source word present.
REQ-006 in_ready  output  1  block can accept the source word this cycle.
REQ-007 s  input  2  destination select: 0..3 maps to channel 0..3; sampled only in the accept cycle.
REQ-008 out_data  output  4*WIDTH  channel k word on bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  4  bit k set: channel k holds a word.
REQ-010 out_ready  input  4  bit k set: channel k sink takes its word this cycle.

Function
REQ-011 Each channel SHALL have one holding register (data plus full flag); out_valid[k] SHALL equal full[k].
REQ-012 Source accept SHALL occur when in_valid and in_ready are both 1 on a rising edge; channel drain SHALL occur when out_valid[k] and out_ready[k] are both 1.
REQ-013 in_ready SHALL be 1 when the destination channel is empty or is draining this cycle: !full[d] || out_ready[d], where d is the destination.
REQ-014 in_ready SHALL depend combinationally on s (or the rotate pointer) and out_ready only, never on in_valid.
REQ-015 An accepted word SHALL appear on its channel's out_data with out_valid set on the next cycle (latency 1).
REQ-016 Accept and drain on the same channel in the same cycle SHALL replace the held word with the new word, and full SHALL stay 1, so back-to-back streaming runs at one word per cycle.
REQ-017 A drain with no accept SHALL clear full[k] on the next edge; out_data[k] SHALL then hold its last value.
REQ-018 Channels SHALL be independent: a stalled channel (full, out_ready low) SHALL NOT block accepts to other channels.
REQ-019 out_data[k] and out_valid[k] SHALL stay stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 Only the selected channel's register SHALL be written; no other channel's data or valid SHALL change on an accept.
REQ-021 A change of s while the source is stalled (in_valid=1, in_ready=0) SHALL be legal; the word goes to the channel selected in the accept cycle.

Reset
REQ-022 rst_n low SHALL immediately, without a clock edge, clear full[3:0] (out_valid=0), clear out_data to 0, and clear the rotate pointer when present.
REQ-023 Assertion of rst_n mid-transfer SHALL discard all held words; none SHALL be presented after reset.
REQ-024 After rst_n deasserts, in_ready SHALL be 1 because every channel is empty.

Configuration
REQ-025 Macro DEMUX_ROTATE_EN: when defined, s SHALL be ignored and the destination d SHALL be an internal 2-bit pointer.
REQ-026 The pointer SHALL reset to 0, increment by one after each accept, and wrap from 3 to 0. It SHALL hold while in_ready=0, which gives strict in-order round-robin.
REQ-027 When DEMUX_ROTATE_EN is undefined, d SHALL equal s, no pointer register SHALL exist, and port s SHALL be present in both builds.

Verification
REQ-028 Reset with WIDTH=8: drive rst_n=0 asynchronously mid-cycle -> out_valid=4'b0000 and out_data=0 at once; in_ready=1 after release.
REQ-029 Single route: s=2, in_data=8'hA5, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100 and out_data[23:16]=8'hA5; a second word to s=2 sees in_ready=0.
REQ-030 Streaming: s=1, out_ready[1]=1, words 8'h01..8'h10 on 16 consecutive cycles -> in_ready=1 throughout; channel 1 outputs 01..10 in order, one per cycle.
REQ-031 Stall isolation: channel 0 full with out_ready[0]=0; send 8'h3C to s=3 -> accepted at once; out_valid=4'b1001 and the channel 0 word is unchanged.
REQ-032 Same-cycle replace: channel 1 holds 8'h11; in the same cycle set out_ready[1]=1 and send 8'h22 to s=1 -> sink takes 8'h11, next cycle out_data[15:8]=8'h22 and out_valid[1]=1.
REQ-033 Rotate build (DEMUX_ROTATE_EN defined): all out_ready=1, words 8'h10..8'h15, s held at 0 -> words go to channels 0,1,2,3,0,1; pointer wraps 3->0.
